// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory waits.
// Mealy enable decode with sticky memory-timeout flag and perf counters.
module hazard_scheduler #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Registro1,
  input  logic [REG_W-1:0] Registro2,
  input  logic             uses_rs2,
  input  logic [REG_W-1:0] Rd_execute,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clear_counters,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(LAST);

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT,
    TIMEOUT
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_stall;
  logic            lu_hazard;
  logic            to_hit;
  logic            flush_ev;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu_hazard = ex_memread & (Rd_execute != '0) &
                     ((Rd_execute == Registro1) |
                      (uses_rs2 & (Rd_execute == Registro2)));
  assign to_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WC_LAST);

  // Enable decode and next state; a frozen pipe outranks a branch,
  // which in turn squashes any load-use hazard on the ID instruction.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    flush_ev   = 1'b0;
    nxt        = RUN;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == TIMEOUT) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      nxt        = TIMEOUT;
    end else if (mem_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      nxt        = to_hit ? TIMEOUT : MEM_WAIT;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_ev   = 1'b1;
    end else if (lu_hazard && state == RUN) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      nxt        = LU_STALL;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      if (!mem_stall)
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
      if (nxt == TIMEOUT)
        timeout_err <= 1'b1;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (clear_counters) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_ev && flush_events != '1)
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: two parameterisations on shared
// stimulus, expected enables queued per step, counters modelled here.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] r1 = '0, r2 = '0, rd = '0;
  logic       u2 = 1'b0, mr = 1'b0, br = 1'b0;
  logic       mreq = 1'b0, mrdy = 1'b0, clr = 1'b0;

  logic        b_pc, b_ifw, b_ifl, b_idf, b_hold, b_terr;
  logic [15:0] b_stall, b_flush;
  logic        s_pc, s_ifw, s_ifl, s_idf, s_hold, s_terr;
  logic [1:0]  s_stall, s_flush;

  always #5 clk = ~clk;

  hazard_scheduler u_big (
    .clk(clk), .reset(reset),
    .Registro1(r1), .Registro2(r2), .uses_rs2(u2),
    .Rd_execute(rd), .ex_memread(mr), .branch_taken(br),
    .mem_req(mreq), .mem_ready(mrdy), .clear_counters(clr),
    .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_ifl),
    .idex_flush(b_idf), .pipe_hold(b_hold), .timeout_err(b_terr),
    .stall_cycles(b_stall), .flush_events(b_flush)
  );

  hazard_scheduler #(.MEM_TIMEOUT(4), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset),
    .Registro1(r1), .Registro2(r2), .uses_rs2(u2),
    .Rd_execute(rd), .ex_memread(mr), .branch_taken(br),
    .mem_req(mreq), .mem_ready(mrdy), .clear_counters(clr),
    .pc_write(s_pc), .ifid_write(s_ifw), .ifid_flush(s_ifl),
    .idex_flush(s_idf), .pipe_hold(s_hold), .timeout_err(s_terr),
    .stall_cycles(s_stall), .flush_events(s_flush)
  );

  typedef struct {
    string tag;
    logic  pc, ifw, ifl, idf, hold, terr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_bs = 0, m_bf = 0, m_ss = 0, m_sf = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = q.pop_front();
    chk({e.tag, "/b_pc"},   b_pc,   e.pc);
    chk({e.tag, "/b_ifw"},  b_ifw,  e.ifw);
    chk({e.tag, "/b_ifl"},  b_ifl,  e.ifl);
    chk({e.tag, "/b_idf"},  b_idf,  e.idf);
    chk({e.tag, "/b_hold"}, b_hold, e.hold);
    chk({e.tag, "/b_terr"}, b_terr, 1'b0);
    chk({e.tag, "/s_pc"},   s_pc,   e.pc);
    chk({e.tag, "/s_hold"}, s_hold, e.hold);
    chk({e.tag, "/s_ifl"},  s_ifl,  e.ifl);
    chk({e.tag, "/s_idf"},  s_idf,  e.idf);
    chk({e.tag, "/s_terr"}, s_terr, e.terr);
  endtask

  task automatic chk_cnt(string tag);
    chk({tag, "/b_stall"}, b_stall, m_bs);
    chk({tag, "/b_flush"}, b_flush, m_bf);
    chk({tag, "/s_stall"}, s_stall, m_ss);
    chk({tag, "/s_flush"}, s_flush, m_sf);
  endtask

  task automatic step(
    string tag,
    logic i_br, logic i_mr, logic [4:0] i_rd, logic [4:0] i_r1,
    logic [4:0] i_r2, logic i_u2, logic i_mreq, logic i_mrdy, logic i_clr,
    logic e_pc, logic e_ifw, logic e_ifl, logic e_idf, logic e_hold,
    logic e_terr
  );
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    br = i_br; mr = i_mr; rd = i_rd; r1 = i_r1; r2 = i_r2; u2 = i_u2;
    mreq = i_mreq; mrdy = i_mrdy; clr = i_clr;
    e.tag = tag; e.pc = e_pc; e.ifw = e_ifw; e.ifl = e_ifl;
    e.idf = e_idf; e.hold = e_hold; e.terr = e_terr;
    q.push_back(e);
    #2;
    chk_out();
    @(posedge clk);
    if (i_clr) begin
      m_bs = 0; m_bf = 0; m_ss = 0; m_sf = 0;
    end else begin
      if (!e_pc) begin
        if (m_bs < 65535) m_bs++;
        if (m_ss < 3) m_ss++;
      end
      if (e_ifl) begin
        if (m_bf < 65535) m_bf++;
        if (m_sf < 3) m_sf++;
      end
    end
    #1;
    chk_cnt(tag);
  endtask

  task automatic reset_step(string tag);
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    br = 0; mr = 0; rd = 0; r1 = 0; r2 = 0; u2 = 0;
    mreq = 0; mrdy = 0; clr = 0;
    e.tag = tag; e.pc = 0; e.ifw = 0; e.ifl = 1; e.idf = 1;
    e.hold = 0; e.terr = 0;
    q.push_back(e);
    #2;
    m_bs = 0; m_bf = 0; m_ss = 0; m_sf = 0;
    chk_out();
    chk_cnt({tag, "/async"});
    @(posedge clk);
    #1;
    chk_cnt({tag, "/held"});
  endtask

  initial begin
    reset_step("rst");
    step("idle", 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    step("lu_rs1", 0,1,3,3,0,0, 0,0,0, 0,0,0,1,0,0);
    step("lu_next", 0,1,3,3,0,0, 0,0,0, 1,1,0,0,0,0);
    step("idle2", 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    step("x0", 0,1,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    step("rs2_unused", 0,1,4,1,4,0, 0,0,0, 1,1,0,0,0,0);
    step("rs2_used", 0,1,4,1,4,1, 0,0,0, 0,0,0,1,0,0);
    step("rs2_after", 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    step("br_lu", 1,1,3,3,0,0, 0,0,0, 1,1,1,1,0,0);
    step("br_after", 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    for (int i = 0; i < 3; i++)
      step("mwait", 1,0,0,0,0,0, 1,0,0, 0,0,0,0,1,0);
    step("mready_br", 1,0,0,0,0,0, 1,1,0, 1,1,1,1,0,0);
    step("mwait_lu", 0,1,3,3,0,0, 1,0,0, 0,0,0,0,1,0);
    step("mready_lu", 0,1,3,3,0,0, 1,1,0, 1,1,0,0,0,0);
    step("clear", 0,0,0,0,0,0, 0,0,1, 1,1,0,0,0,0);
    for (int i = 0; i < 4; i++)
      step("to_pre", 0,0,0,0,0,0, 1,0,0, 0,0,0,0,1,0);
    step("to_clr", 0,0,0,0,0,0, 1,0,1, 0,0,0,0,1,1);
    step("to_hold", 0,0,0,0,0,0, 1,0,0, 0,0,0,0,1,1);
    reset_step("to_rst");
    step("post_rst", 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      step("sat_lu", 0,1,5,5,0,0, 0,0,0, 0,0,0,1,0,0);
      step("sat_run", 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    end
    for (int i = 0; i < 4; i++)
      step("sat_br", 1,0,0,0,0,0, 0,0,0, 1,1,1,1,0,0);
    step("sat_clr", 0,1,5,5,0,0, 0,0,1, 0,0,0,1,0,0);
    step("sat_end", 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
